// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
package arm_mem_pkg;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
   typedef enum logic {GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Core fetch/data ports plus the memory port of the arbiter.
// master = arbiter view, slave = core + memory view.
interface shared_mem_arbiter_if #(
   parameter int ADDR_W = arm_mem_pkg::ADDR_W_DEF,
   parameter int DATA_W = arm_mem_pkg::DATA_W_DEF
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [DATA_W-1:0] dm_rdata;
   logic              dm_ready;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              bus_err;

   modport master (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );

   modport slave (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
      input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
   );
endinterface

// File: rtl/shared_mem_arbiter_watchdog.sv
// Counts cycles spent waiting on the memory and flags an access that never completes.
// TIMEOUT = 0 disables the abort entirely.
module arb_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int          CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   logic [CNT_W-1:0] wdog;

   // Wait counter: restarts whenever the arbiter is not waiting on memory.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      wdog <= '0;
      else if (clear)  wdog <= '0;
      else if (enable) wdog <= wdog + 1'b1;
   end

   assign expire = (TIMEOUT != 0) && enable && (wdog == CNT_W'(LAST));
endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch (I) and
// data (D) ports. D has fixed priority, but after MAX_D_BURST consecutive D
// grants with a fetch waiting, the fetch is served. One access in flight.
module shared_mem_arbiter import arm_mem_pkg::*; #(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_D_BURST = 4,
   parameter int TIMEOUT     = 255
) (
   input logic                  clk,
   input logic                  reset,
   shared_mem_arbiter_if.master bus
);
   localparam int                  STREAK_W   = $clog2(MAX_D_BURST + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

   arb_state_t          state;
   grant_t              grantSel;
   logic [STREAK_W-1:0] dStreak;
   logic                grantD, grantI, grantWe;
   logic [ADDR_W-1:0]   grantAddr;
   logic [DATA_W-1:0]   grantWdata;
   logic [DATA_W-1:0]   capData;
   logic                expire;

   arb_watchdog #(.TIMEOUT(TIMEOUT)) uWdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (state != ARB_BUSY),
      .enable (state == ARB_BUSY),
      .expire (expire)
   );

   // Grant selection and request mux; D loses only when the fetch has starved long enough.
   always_comb begin
      grantD     = bus.dm_req && !(bus.if_req && dStreak == STREAK_MAX);
      grantI     = !grantD && bus.if_req;
      grantWe    = grantD && bus.dm_we;
      grantAddr  = grantD ? bus.dm_addr : bus.if_addr;
      grantWdata = grantD ? bus.dm_wdata : '0;
   end

   // Data returned to the granted port: stores and aborted accesses return zero.
   always_comb begin
      capData = '0;
      if (bus.mem_ack && !(grantSel == GNT_D && bus.mem_we)) capData = bus.mem_rdata;
   end

   // Arbiter FSM with all core- and memory-facing outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ARB_IDLE;
         grantSel      <= GNT_I;
         dStreak       <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.if_ready  <= 1'b0;
         bus.dm_ready  <= 1'b0;
         bus.bus_err   <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (grantD || grantI) begin
                  grantSel      <= grantD ? GNT_D : GNT_I;
                  bus.mem_req   <= 1'b1;
                  bus.mem_we    <= grantWe;
                  bus.mem_addr  <= grantAddr;
                  bus.mem_wdata <= grantWdata;
                  // Streak only grows while a fetch is actually being held off.
                  if (grantD && bus.if_req)
                     dStreak <= (dStreak == STREAK_MAX) ? dStreak : dStreak + 1'b1;
                  else
                     dStreak <= '0;
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               // A completing ack wins over a watchdog expiry in the same cycle.
               if (bus.mem_ack || expire) begin
                  bus.mem_req <= 1'b0;
                  bus.bus_err <= !bus.mem_ack;
                  if (grantSel == GNT_D) begin
                     bus.dm_rdata <= capData;
                     bus.dm_ready <= 1'b1;
                  end else begin
                     bus.if_rdata <= capData;
                     bus.if_ready <= 1'b1;
                  end
                  state <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               // No grant here so the requester can drop its req before we look again.
               bus.if_ready <= 1'b0;
               bus.dm_ready <= 1'b0;
               bus.bus_err  <= 1'b0;
               state        <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end
endmodule
